ppm_encoder: RTL and testbench
==============================

# ppm_encoder

Pulse-position-modulation transmitter, the encoding counterpart of the team's PPM decoder path. Accepts one `BITS`-wide symbol per valid/ready handshake and emits a frame of `2**BITS` data slots plus `GUARD_SLOTS` guard slots. Each slot is `SLOT_CYCLES` clocks long, and a single pulse is placed in the slot indexed by the symbol value. The block sits between the payload source and the optical/line driver and runs entirely in the system clock domain.

## Interface
- `BITS`, default 2: bits per symbol; the frame has `2**BITS` data slots (4-PPM by default).
- `SLOT_CYCLES`, default 128: clocks per slot; must be at least 2.
- `PULSE_CYCLES`, default 64: clocks the pulse stays high, counted from slot start; legal range 1..`SLOT_CYCLES`.
- `GUARD_SLOTS`, default 1: empty slots appended after the data slots; 0 is legal.
- `clk` in 1: system clock; every register is rising-edge.
- `rst_n` in 1: reset, asynchronous, active-low. One clock; reset is asynchronous and active-low.
- `data_in` in `BITS`: symbol value; sampled only on acceptance.
- `data_valid` in 1: source has a symbol.
- `data_ready` out 1: encoder can accept a symbol this cycle.
- `ppm_out` out 1: modulated pulse stream.
- `busy` out 1: a frame is in progress.
- `sym_done` out 1: one-cycle strobe on the last cycle of each frame.

## Operation
- States:
  - IDLE: no frame in progress.
  - SEND: counting data slots 0..`2**BITS`-1.
  - GUARD: counting guard slots; skipped entirely when `GUARD_SLOTS`=0.
- Counters:
  - `cyc_cnt` counts 0..`SLOT_CYCLES`-1 and wraps to 0 at slot end.
  - `slot_cnt` counts 0..`2**BITS`+`GUARD_SLOTS`-1.
  - Widths use `$clog2`; no counter ever exceeds its terminal value.
- Acceptance means `data_valid && data_ready` at a rising edge.
  - On acceptance, `data_in` is captured into `sym_q`, the state moves to SEND, and both counters are cleared.
- `data_ready` = (state==IDLE) OR (last cycle of frame), i.e. `slot_cnt` and `cyc_cnt` both terminal.
  - Acceptance on the last cycle starts the next frame with no idle gap.
  - At the last cycle without acceptance, the state returns to IDLE.
- `ppm_out` = (state==SEND) && (`slot_cnt`==`sym_q`) && (`cyc_cnt` < `PULSE_CYCLES`).
  - It is decoded from registers only and has no `data_in` path.
- `busy` = state != IDLE.
- `sym_done` = last cycle of frame.
- `data_valid` while `data_ready` is low is ignored; the source must hold its symbol.
- Data-to-guard transition: SEND moves to GUARD at the end of slot `2**BITS`-1 when `GUARD_SLOTS`>0. `slot_cnt` keeps counting through guard slots.

## Timing
- Reset values: state IDLE, counters 0, `sym_q` 0, `ppm_out` 0, `busy` 0, `sym_done` 0, `data_ready` 1.
- Asserting `rst_n` mid-frame clears everything asynchronously.
  - `ppm_out` drops without waiting for a clock edge.
  - The interrupted symbol is lost, not retransmitted.
- Frame length is F = (`2**BITS`+`GUARD_SLOTS`)·`SLOT_CYCLES` cycles, counted from the cycle after acceptance.
- With acceptance at edge t, the pulse is high in cycles t+1+`sym_q`·`SLOT_CYCLES` through that value +`PULSE_CYCLES`-1.
- `sym_done` and `data_ready` are high in cycle t+F.
- Back-to-back throughput is one symbol per F cycles exactly.
- With `GUARD_SLOTS`=0 and `PULSE_CYCLES`=`SLOT_CYCLES`, symbol max followed by symbol 0 yields a continuous 2·`SLOT_CYCLES`-cycle high. This is legal and required.

## Structure
- Package `ppm_pkg` holds:
  - state enum `ppm_state_t` {IDLE, SEND, GUARD};
  - default constants `PPM_BITS`, `PPM_SLOT_CYCLES`, `PPM_PULSE_CYCLES`, `PPM_GUARD_SLOTS`, shared with the decoder.
- Sub-module `ppm_slot_timer` contains:
  - the `cyc_cnt`/`slot_cnt` pair with clear and enable;
  - outputs `slot_end` and `frame_end`.
- The FSM, `sym_q` and output decode stay in `ppm_encoder`.

## Test plan
All scenarios use default parameters unless stated otherwise.
- **Reset:** hold `rst_n`=0 for 5 cycles → `ppm_out`=0, `busy`=0, `sym_done`=0, `data_ready`=1 throughout.
- **Single symbol:** symbol 2 accepted at edge 0 → `ppm_out` high in cycles 257..320 only, `sym_done` and `data_ready` high in cycle 640, then IDLE.
- **Back-to-back:** symbols 0 then 3, with `data_valid` held high → pulses at cycles 1..64 and 1025..1088; second acceptance happens at cycle 640; no idle cycle between frames.
- **Valid while busy:** `data_valid`=1 with `data_in` changing during a frame → no capture and the pulse position is unchanged; capture occurs only at cycle 640.
- **Reset mid-pulse:** `rst_n` asserted at cycle 280 of a symbol-2 frame → `ppm_out` low immediately; after release, IDLE with `data_ready`=1.
- **Zero guard, full-width pulse:** `GUARD_SLOTS`=0, `PULSE_CYCLES`=128, symbols 3 then 0 → continuous high over cycles 385..640.

Source files
------------

// File: rtl/ppm_pkg.sv
// Shared PPM definitions: FSM state encoding and default framing constants
// used by both the encoder and the decoder path.
package ppm_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEND  = 2'd1,
    GUARD = 2'd2
  } ppm_state_t;

  localparam int unsigned PPM_BITS         = 2;
  localparam int unsigned PPM_SLOT_CYCLES  = 128;
  localparam int unsigned PPM_PULSE_CYCLES = 64;
  localparam int unsigned PPM_GUARD_SLOTS  = 1;

endpackage

// File: rtl/ppm_slot_timer.sv
// Cycle-in-slot and slot-in-frame counter pair. Clear has priority over
// enable; both counters wrap to zero together at the end of the frame.
module ppm_slot_timer
  import ppm_pkg::*;
#(
  parameter int unsigned SLOT_CYCLES = PPM_SLOT_CYCLES,
  parameter int unsigned TOTAL_SLOTS = (2 ** PPM_BITS) + PPM_GUARD_SLOTS
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           clr,
  input  logic                           en,
  output logic [$clog2(SLOT_CYCLES)-1:0] cyc_cnt,
  output logic [$clog2(TOTAL_SLOTS)-1:0] slot_cnt,
  output logic                           slot_end,
  output logic                           frame_end
);

  localparam int unsigned CW = $clog2(SLOT_CYCLES);
  localparam int unsigned SW = $clog2(TOTAL_SLOTS);
  localparam logic [CW-1:0] CYC_LAST  = CW'(SLOT_CYCLES - 1);
  localparam logic [SW-1:0] SLOT_LAST = SW'(TOTAL_SLOTS - 1);

  logic [CW-1:0] cyc_cnt_q, cyc_cnt_d;
  logic [SW-1:0] slot_cnt_q, slot_cnt_d;

  assign slot_end  = en && (cyc_cnt_q == CYC_LAST);
  assign frame_end = slot_end && (slot_cnt_q == SLOT_LAST);
  assign cyc_cnt   = cyc_cnt_q;
  assign slot_cnt  = slot_cnt_q;

  // Next-count logic: clear, otherwise advance and wrap at terminal values.
  always_comb begin
    cyc_cnt_d  = cyc_cnt_q;
    slot_cnt_d = slot_cnt_q;
    if (clr) begin
      cyc_cnt_d  = '0;
      slot_cnt_d = '0;
    end else if (en) begin
      if (slot_end) begin
        cyc_cnt_d  = '0;
        slot_cnt_d = frame_end ? '0 : slot_cnt_q + 1'b1;
      end else begin
        cyc_cnt_d = cyc_cnt_q + 1'b1;
      end
    end
  end

  // Counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc_cnt_q  <= '0;
      slot_cnt_q <= '0;
    end else begin
      cyc_cnt_q  <= cyc_cnt_d;
      slot_cnt_q <= slot_cnt_d;
    end
  end

endmodule

// File: rtl/ppm_encoder.sv
// PPM transmitter: one symbol per handshake, one pulse per frame placed in
// the data slot selected by the symbol, followed by optional guard slots.
//
//   state | meaning
//   IDLE  | no frame in progress, ready for a symbol
//   SEND  | counting data slots 0..2**BITS-1, pulse in slot sym_q
//   GUARD | counting empty guard slots (never entered when GUARD_SLOTS=0)
module ppm_encoder
  import ppm_pkg::*;
#(
  parameter int unsigned BITS         = PPM_BITS,
  parameter int unsigned SLOT_CYCLES  = PPM_SLOT_CYCLES,
  parameter int unsigned PULSE_CYCLES = PPM_PULSE_CYCLES,
  parameter int unsigned GUARD_SLOTS  = PPM_GUARD_SLOTS
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [BITS-1:0] data_in,
  input  logic            data_valid,
  output logic            data_ready,
  output logic            ppm_out,
  output logic            busy,
  output logic            sym_done
);

  localparam int unsigned DATA_SLOTS  = 2 ** BITS;
  localparam int unsigned TOTAL_SLOTS = DATA_SLOTS + GUARD_SLOTS;
  localparam int unsigned CW          = $clog2(SLOT_CYCLES);
  localparam int unsigned SW          = $clog2(TOTAL_SLOTS);
  localparam logic [SW-1:0] DATA_LAST = SW'(DATA_SLOTS - 1);
  localparam bit HAS_GUARD            = (GUARD_SLOTS > 0);

  ppm_state_t    state_q, state_d;
  logic [BITS-1:0] sym_q, sym_d;

  logic [CW-1:0] cyc_cnt;
  logic [SW-1:0] slot_cnt;
  logic          slot_end;
  logic          frame_end;
  logic          accept;
  logic          running;

  assign running    = (state_q != IDLE);
  assign data_ready = (state_q == IDLE) || frame_end;
  assign accept     = data_valid && data_ready;
  assign busy       = running;
  assign sym_done   = frame_end;

  // Pulse is decoded from registered state only, so reset kills it at once.
  assign ppm_out = (state_q == SEND) && (slot_cnt == SW'(sym_q)) &&
                   (32'(cyc_cnt) < PULSE_CYCLES);

  ppm_slot_timer #(
    .SLOT_CYCLES (SLOT_CYCLES),
    .TOTAL_SLOTS (TOTAL_SLOTS)
  ) u_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (accept),
    .en        (running),
    .cyc_cnt   (cyc_cnt),
    .slot_cnt  (slot_cnt),
    .slot_end  (slot_end),
    .frame_end (frame_end)
  );

  // Next-state and symbol capture; acceptance on the last cycle chains frames.
  always_comb begin
    state_d = state_q;
    sym_d   = sym_q;
    if (accept) begin
      state_d = SEND;
      sym_d   = data_in;
    end else if (frame_end) begin
      state_d = IDLE;
    end else if ((state_q == SEND) && slot_end && (slot_cnt == DATA_LAST)) begin
      state_d = HAS_GUARD ? GUARD : IDLE;
    end
  end

  // FSM and symbol registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sym_q   <= '0;
    end else begin
      state_q <= state_d;
      sym_q   <= sym_d;
    end
  end

endmodule

// File: tb/tb_ppm_encoder.sv
// Directed bench for ppm_encoder: default-parameter instance plus a
// zero-guard, full-width-pulse instance.
module tb_ppm_encoder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] data_in = 2'd0;
  logic       data_valid = 1'b0;
  logic       data_ready, ppm_out, busy, sym_done;

  logic [1:0] data_in1 = 2'd0;
  logic       data_valid1 = 1'b0;
  logic       data_ready1, ppm_out1, busy1, sym_done1;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  ppm_encoder u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .data_in    (data_in),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .ppm_out    (ppm_out),
    .busy       (busy),
    .sym_done   (sym_done)
  );

  ppm_encoder #(
    .BITS         (2),
    .SLOT_CYCLES  (128),
    .PULSE_CYCLES (128),
    .GUARD_SLOTS  (0)
  ) u_dut_ng (
    .clk        (clk),
    .rst_n      (rst_n),
    .data_in    (data_in1),
    .data_valid (data_valid1),
    .data_ready (data_ready1),
    .ppm_out    (ppm_out1),
    .busy       (busy1),
    .sym_done   (sym_done1)
  );

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk_all(input string tag, input logic e_ppm, input logic e_busy,
                         input logic e_done, input logic e_rdy);
    chk({tag, ".ppm_out"},    ppm_out,    e_ppm);
    chk({tag, ".busy"},       busy,       e_busy);
    chk({tag, ".sym_done"},   sym_done,   e_done);
    chk({tag, ".data_ready"}, data_ready, e_rdy);
  endtask

  initial begin
    // Reset held for 5 cycles.
    @(posedge clk);
    #1;
    for (int i = 0; i < 5; i++) begin
      chk_all("reset", 1'b0, 1'b0, 1'b0, 1'b1);
      chk("reset.ng_ready", data_ready1, 1'b1);
      step();
    end
    @(negedge clk);
    rst_n = 1'b1;
    step();
    step();
    chk_all("idle", 1'b0, 1'b0, 1'b0, 1'b1);

    // Single symbol 2.
    data_in = 2'd2;
    data_valid = 1'b1;
    cyc = 0;
    step();
    data_valid = 1'b0;
    data_in = 2'd0;
    for (int c = 1; c <= 645; c++) begin
      chk_all("single", (c >= 257 && c <= 320), (c <= 640), (c == 640), (c >= 640));
      step();
    end

    // Back-to-back 0 then 3 with valid held high.
    data_in = 2'd0;
    data_valid = 1'b1;
    cyc = 0;
    step();
    data_in = 2'd3;
    for (int c = 1; c <= 1285; c++) begin
      chk_all("b2b", (c >= 1 && c <= 64) || (c >= 1025 && c <= 1088),
              (c <= 1280), (c == 640 || c == 1280), (c == 640 || c >= 1280));
      step();
      if (c == 640) data_valid = 1'b0;
    end

    // Valid held while busy with changing data; only the cycle-640 value counts.
    data_in = 2'd1;
    data_valid = 1'b1;
    cyc = 0;
    step();
    for (int c = 1; c <= 1285; c++) begin
      chk_all("vbusy", (c >= 129 && c <= 192) || (c >= 897 && c <= 960),
              (c <= 1280), (c == 640 || c == 1280), (c == 640 || c >= 1280));
      step();
      if (c < 639)       data_in = 2'(c);
      else if (c == 639) data_in = 2'd2;
      else               data_valid = 1'b0;
    end

    // Reset asserted mid-pulse of a symbol-2 frame.
    data_in = 2'd2;
    data_valid = 1'b1;
    cyc = 0;
    step();
    data_valid = 1'b0;
    while (cyc < 280) step();
    chk("midrst.pre_ppm", ppm_out, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst.async_ppm",   ppm_out,    1'b0);
    chk("midrst.async_busy",  busy,       1'b0);
    chk("midrst.async_ready", data_ready, 1'b1);
    step();
    step();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_all("midrst.after", 1'b0, 1'b0, 1'b0, 1'b1);
    end

    // Zero guard, full-width pulse: 3 then 0 forms one continuous high.
    data_in1 = 2'd3;
    data_valid1 = 1'b1;
    cyc = 0;
    step();
    data_in1 = 2'd0;
    for (int c = 1; c <= 1030; c++) begin
      chk("ng.ppm_out",  ppm_out1,   (c >= 385 && c <= 640));
      chk("ng.busy",     busy1,      (c <= 1024));
      chk("ng.sym_done", sym_done1,  (c == 512 || c == 1024));
      chk("ng.ready",    data_ready1, (c == 512 || c >= 1024));
      step();
      if (c == 512) data_valid1 = 1'b0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
